// File: rtl/ahb_lite_mi_bus.sv
// ahb_lite_mi_bus: arbitrates AHB-Lite initiators onto one path and decodes to windowed responders.
// Define AHB_LITE_MI_BUS_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ahb_lite_mi_bus #(
    parameter int AHB_LITE_ADDR_WIDTH = 32,
    parameter int AHB_LITE_DATA_WIDTH = 32,
    parameter int NUM_INITIATORS      = 2,
    parameter int NUM_RESPONDERS      = 8
) (
    input  logic                                                 hclk,
    input  logic                                                 hreset,
    input  logic [NUM_INITIATORS-1:0][AHB_LITE_ADDR_WIDTH-1:0]   i_haddr,
    input  logic [NUM_INITIATORS-1:0][AHB_LITE_DATA_WIDTH-1:0]   i_hwdata,
    input  logic [NUM_INITIATORS-1:0]                            i_hwrite,
    input  logic [NUM_INITIATORS-1:0][1:0]                       i_htrans,
    input  logic [NUM_INITIATORS-1:0][2:0]                       i_hsize,
    output logic [NUM_INITIATORS-1:0]                            i_hready,
    output logic [NUM_INITIATORS-1:0]                            i_hresp,
    output logic [NUM_INITIATORS-1:0][AHB_LITE_DATA_WIDTH-1:0]   i_hrdata,
    output logic [NUM_RESPONDERS-1:0][AHB_LITE_ADDR_WIDTH-1:0]   r_haddr,
    output logic [NUM_RESPONDERS-1:0][AHB_LITE_DATA_WIDTH-1:0]   r_hwdata,
    output logic [NUM_RESPONDERS-1:0]                            r_hwrite,
    output logic [NUM_RESPONDERS-1:0][1:0]                       r_htrans,
    output logic [NUM_RESPONDERS-1:0][2:0]                       r_hsize,
    output logic [NUM_RESPONDERS-1:0]                            r_hsel,
    output logic [NUM_RESPONDERS-1:0]                            r_hready,
    input  logic [NUM_RESPONDERS-1:0][AHB_LITE_DATA_WIDTH-1:0]   r_hrdata,
    input  logic [NUM_RESPONDERS-1:0]                            r_hresp,
    input  logic [NUM_RESPONDERS-1:0]                            r_hreadyout,
    input  logic [NUM_RESPONDERS-1:0]                            resp_disable_i,
    output logic [NUM_RESPONDERS-1:0]                            access_blocked_o,
    input  logic [NUM_RESPONDERS-1:0][AHB_LITE_ADDR_WIDTH-1:0]   start_addr_i,
    input  logic [NUM_RESPONDERS-1:0][AHB_LITE_ADDR_WIDTH-1:0]   end_addr_i,
    input  logic                                                 force_bus_idle
);
    localparam int NI = NUM_INITIATORS;
    localparam int NR = NUM_RESPONDERS;
    localparam int IW = NI > 1 ? $clog2(NI) : 1;
    localparam int RW = NR > 1 ? $clog2(NR) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

    state_t                         r_state, w_state_nxt;
    logic                           r_dp_valid, r_dp_err;
    logic [IW-1:0]                  r_dp_owner;
    logic [RW-1:0]                  r_dp_resp_idx;
    logic [IW-1:0]                  w_start, w_cand, w_gnt;
    logic [RW-1:0]                  w_hit_idx;
    logic [NI-1:0]                  w_req, w_own;
    logic [AHB_LITE_ADDR_WIDTH-1:0] w_haddr;
    logic                           w_bus_rdy, w_found, w_hit, w_err, w_accept;

    assign w_bus_rdy = !r_dp_valid ? 1'b1 : r_dp_err ? (r_state == ST_ERR2) : r_hreadyout[r_dp_resp_idx];
    assign w_accept  = w_bus_rdy && !force_bus_idle && w_found;
    assign w_haddr   = i_haddr[w_gnt];
    assign w_err     = !w_hit || resp_disable_i[w_hit_idx];

`ifdef AHB_LITE_MI_BUS_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [IW-1:0] r_rr_ptr;
    // Pointer holds the index searched first, i.e. one past the last accepted grant.
    always_ff @(posedge hclk) begin
        if (hreset)
            r_rr_ptr <= '0;
        else if (w_accept)
            r_rr_ptr <= IW'((int'(w_gnt) + 1) % NI);
    end
    assign w_start = r_rr_ptr;
`endif

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int i = 0; i < NI; i++)
            w_req[i] = i_htrans[i][1];
        for (int k = 0; k < NI; k++) begin
            w_cand = IW'((int'(w_start) + k) % NI);
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    // Descending scan so the lowest matching window wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int j = NR - 1; j >= 0; j--) begin
            if (w_haddr >= start_addr_i[j] && w_haddr <= end_addr_i[j]) begin
                w_hit     = 1'b1;
                w_hit_idx = RW'(j);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NR; j++) begin
            r_hsel[j]           = w_accept && !w_err && w_hit_idx == RW'(j);
            r_htrans[j]         = r_hsel[j] ? i_htrans[w_gnt] : 2'b00;
            access_blocked_o[j] = w_accept && w_hit && resp_disable_i[j] && w_hit_idx == RW'(j);
            r_haddr[j]          = w_haddr;
            r_hwrite[j]         = i_hwrite[w_gnt];
            r_hsize[j]          = i_hsize[w_gnt];
            r_hwdata[j]         = i_hwdata[r_dp_owner];
            r_hready[j]         = w_bus_rdy;
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            w_own[i]    = r_dp_valid && r_dp_owner == IW'(i);
            i_hready[i] = (w_own[i] || (w_accept && w_gnt == IW'(i))) ? w_bus_rdy : !w_req[i];
            i_hresp[i]  = w_own[i] && (r_dp_err || r_hresp[r_dp_resp_idx]);
            i_hrdata[i] = (w_own[i] && !r_dp_err) ? r_hrdata[r_dp_resp_idx] : '0;
        end
    end

    always_comb begin
        w_state_nxt = (r_state == ST_ERR1) ? ST_ERR2 : (w_accept && w_err) ? ST_ERR1 : ST_IDLE;
    end

    always_ff @(posedge hclk) begin
        r_state <= hreset ? ST_IDLE : w_state_nxt;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_dp_valid    <= 1'b0;
            r_dp_err      <= 1'b0;
            r_dp_owner    <= '0;
            r_dp_resp_idx <= '0;
        end else if (w_bus_rdy) begin
            r_dp_valid    <= w_accept;
            r_dp_err      <= w_accept && w_err;
            r_dp_owner    <= w_gnt;
            r_dp_resp_idx <= w_hit_idx;
        end
    end
endmodule

// File: tb/tb_ahb_lite_mi_bus.sv
// tb_ahb_lite_mi_bus: random initiator/responder traffic checked against a transaction-level bus model.
`timescale 1ns/1ps
module tb_ahb_lite_mi_bus;
    localparam int NI = 2;
    localparam int NR = 8;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    logic [NI-1:0][31:0] i_haddr, i_hwdata, i_hrdata;
    logic [NI-1:0]       i_hwrite, i_hready, i_hresp;
    logic [NI-1:0][1:0]  i_htrans;
    logic [NI-1:0][2:0]  i_hsize;
    logic [NR-1:0][31:0] r_haddr, r_hwdata, r_hrdata, start_addr_i, end_addr_i;
    logic [NR-1:0]       r_hwrite, r_hsel, r_hready, r_hresp, r_hreadyout, resp_disable_i, access_blocked_o;
    logic [NR-1:0][1:0]  r_htrans;
    logic [NR-1:0][2:0]  r_hsize;
    logic                force_bus_idle;

    always #5 hclk = ~hclk;

    ahb_lite_mi_bus #(.NUM_INITIATORS(NI), .NUM_RESPONDERS(NR)) dut (
        .hclk(hclk), .hreset(hreset),
        .i_haddr(i_haddr), .i_hwdata(i_hwdata), .i_hwrite(i_hwrite), .i_htrans(i_htrans),
        .i_hsize(i_hsize), .i_hready(i_hready), .i_hresp(i_hresp), .i_hrdata(i_hrdata),
        .r_haddr(r_haddr), .r_hwdata(r_hwdata), .r_hwrite(r_hwrite), .r_htrans(r_htrans),
        .r_hsize(r_hsize), .r_hsel(r_hsel), .r_hready(r_hready), .r_hrdata(r_hrdata),
        .r_hresp(r_hresp), .r_hreadyout(r_hreadyout), .resp_disable_i(resp_disable_i),
        .access_blocked_o(access_blocked_o), .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .force_bus_idle(force_bus_idle)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    logic [31:0] lo[NR], hi[NR], pool[12], a_addr[NI];
    logic [1:0]  a_tr[NI];
    logic [2:0]  a_sz[NI];
    logic        a_wr[NI];
    bit          pend[NI], infl[NI];
    int          own = -1, tgt = -1, estg = 0, rr = 0;

    initial begin
        logic [NI-1:0]      e_rdy, e_resp;
        logic [NI-1:0][31:0] e_rd;
        logic [NR-1:0]      e_sel, e_blk;
        logic [NR-1:0][1:0] e_tr;
        bit rdy, rst_now;
        int gnt, hit;
        lo[0] = 32'h8000_0000;
        hi[0] = 32'h8000_0FFF;
        for (int j = 1; j < 7; j++) begin
            lo[j] = 32'((j - 1) * 4096);
            hi[j] = lo[j] + 32'h0FFF;
        end
        lo[7] = 32'h1800;
        hi[7] = 32'h6FFF;
        pool = '{32'h1004, 32'h1000, 32'h1FFF, 32'h0FFF, 32'h1800, 32'h2000,
                 32'h6000, 32'hFFFF_0000, 32'h8000_0000, 32'h8000_1000, 32'h5FFF, 32'h2FFF};
        for (int j = 0; j < NR; j++) begin
            start_addr_i[j] = lo[j];
            end_addr_i[j]   = hi[j];
        end
        i_haddr = '0; i_hwdata = '0; i_hwrite = '0; i_htrans = '0; i_hsize = '0;
        r_hrdata = '0; r_hresp = '0; r_hreadyout = '1; resp_disable_i = 8'h08; force_bus_idle = 1'b0;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        #3;
        check("rst_hready", 256'(i_hready), 256'(2'b11));
        check("rst_hresp", 256'(i_hresp), 256'(0));
        check("rst_hrdata", 256'(i_hrdata), 256'(0));
        check("rst_hsel", 256'(r_hsel), 256'(0));
        check("rst_htrans", 256'(r_htrans), 256'(0));
        check("rst_blocked", 256'(access_blocked_o), 256'(0));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge hclk);
            #1;
            rst_now = (cyc == 1500);
            hreset = rst_now;
            force_bus_idle = ($urandom_range(0, 9) == 0);
            resp_disable_i = {2'b00, ($urandom_range(0, 3) == 0), 1'b0, 1'b1, 3'b000};
            for (int j = 0; j < NR; j++) begin
                r_hreadyout[j] = ($urandom_range(0, 9) < 7);
                r_hrdata[j]    = $urandom;
                r_hresp[j]     = ($urandom_range(0, 19) == 0);
            end
            for (int i = 0; i < NI; i++) begin
                if (rst_now) begin
                    pend[i] = 0;
                    infl[i] = 0;
                end else if (!pend[i] && !infl[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]   = 1;
                    a_addr[i] = pool[$urandom_range(0, 11)];
                    a_tr[i]   = 2'($urandom_range(2, 3));
                    a_wr[i]   = ($urandom_range(0, 1) == 1);
                    a_sz[i]   = 3'($urandom_range(0, 2));
                end
                i_htrans[i] = pend[i] ? a_tr[i] : 2'b00;
                i_haddr[i]  = pend[i] ? a_addr[i] : $urandom;
                i_hwrite[i] = pend[i] ? a_wr[i] : 1'b0;
                i_hsize[i]  = pend[i] ? a_sz[i] : 3'b000;
                i_hwdata[i] = $urandom;
            end
            #3;
            rdy = (own < 0) ? 1 : (tgt < 0) ? (estg == 2) : r_hreadyout[tgt];
            gnt = -1;
            if (rdy && !force_bus_idle)
                for (int k = 0; k < NI; k++)
                    if (gnt < 0 && pend[(rr + k) % NI]) gnt = (rr + k) % NI;
            hit = -1;
            if (gnt >= 0)
                for (int j = NR - 1; j >= 0; j--)
                    if (a_addr[gnt] >= lo[j] && a_addr[gnt] <= hi[j]) hit = j;
            e_sel = '0; e_blk = '0; e_tr = '0;
            if (hit >= 0) begin
                if (resp_disable_i[hit]) e_blk[hit] = 1'b1;
                else begin
                    e_sel[hit] = 1'b1;
                    e_tr[hit]  = a_tr[gnt];
                end
            end
            for (int i = 0; i < NI; i++) begin
                e_rdy[i]  = (i == gnt || i == own) ? rdy : !pend[i];
                e_resp[i] = (i == own) && (tgt < 0 || r_hresp[tgt]);
                e_rd[i]   = (i == own && tgt >= 0) ? r_hrdata[tgt] : 32'h0;
            end
            check($sformatf("hready@%0d", cyc), 256'(i_hready), 256'(e_rdy));
            check($sformatf("hresp@%0d", cyc), 256'(i_hresp), 256'(e_resp));
            check($sformatf("hrdata@%0d", cyc), 256'(i_hrdata), 256'(e_rd));
            check($sformatf("hsel@%0d", cyc), 256'(r_hsel), 256'(e_sel));
            check($sformatf("htrans@%0d", cyc), 256'(r_htrans), 256'(e_tr));
            check($sformatf("blocked@%0d", cyc), 256'(access_blocked_o), 256'(e_blk));
            check($sformatf("r_hready@%0d", cyc), 256'(r_hready), 256'({NR{rdy}}));
            if (gnt >= 0) begin
                check($sformatf("r_haddr@%0d", cyc), 256'(r_haddr[3]), 256'(a_addr[gnt]));
                check($sformatf("r_hwrite@%0d", cyc), 256'(r_hwrite), 256'({NR{a_wr[gnt]}}));
                check($sformatf("r_hsize@%0d", cyc), 256'(r_hsize[5]), 256'(a_sz[gnt]));
            end
            if (own >= 0)
                check($sformatf("r_hwdata@%0d", cyc), 256'(r_hwdata[1]), 256'(i_hwdata[own]));
            if (rst_now) begin
                own = -1; tgt = -1; estg = 0; rr = 0;
            end else if (rdy) begin
                if (own >= 0) infl[own] = 0;
                if (gnt >= 0) begin
                    own  = gnt;
                    tgt  = (hit >= 0 && !resp_disable_i[hit]) ? hit : -1;
                    estg = 1;
`ifndef AHB_LITE_MI_BUS_FIXED_PRIO_EN
                    rr   = (gnt + 1) % NI;
`endif
                    pend[gnt] = 0;
                    infl[gnt] = 1;
                end else own = -1;
            end else if (tgt < 0) estg = 2;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
